spi_load_ctrl: RTL and testbench

Serial program/data loader controller for the tiny processor. It sits between the SPI-style master pins and the instruction and data caches. It deframes the MOSI bit stream selected by the instruction or data chip select into address/data words and issues single-cycle write strobes to the addressed cache. It also arbitrates cache-write ownership against the processor run request and flags malformed frames.

---
 rtl/spi_load_ctrl_if.sv | 29 ++
 rtl/spi_load_ctrl.sv | 139 +++++++++++++
 tb/tb_spi_load_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_load_ctrl_if.sv
// Pin bundle between the serial loader master and spi_load_ctrl.
interface spi_load_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              csi_n;
    logic              csd_n;
    logic              run_in;
    logic              mosi_in;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic              icache_wen_out;
    logic              dcache_wen_out;
    logic              run_out;
    logic              busy_out;
    logic              frame_err_out;

    modport master (
        output csi_n, csd_n, run_in, mosi_in,
        input  wr_addr_out, wr_data_out, icache_wen_out, dcache_wen_out,
               run_out, busy_out, frame_err_out
    );

    modport slave (
        input  csi_n, csd_n, run_in, mosi_in,
        output wr_addr_out, wr_data_out, icache_wen_out, dcache_wen_out,
               run_out, busy_out, frame_err_out
    );
endinterface

// File: rtl/spi_load_ctrl.sv
// Serial loader: deframes MOSI into instruction/data cache writes and hands the caches to the
// processor on run. Define LOADER_PARITY_EN to append a trailing even-parity bit to every frame.
module spi_load_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            rst,
    spi_load_ctrl_if.slave bus
);
    localparam int PAYLOAD_W = DATA_W + ADDR_W;
`ifdef LOADER_PARITY_EN
    localparam int FRAME_LEN = PAYLOAD_W + 1;
`else
    localparam int FRAME_LEN = PAYLOAD_W;
`endif
    localparam int               SHREG_W  = FRAME_LEN - 1;
    localparam int               CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_I, SHIFT_D, RUN} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SHREG_W-1:0]  shreg_q, shreg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                iwen_q, iwen_d;
    logic                dwen_q, dwen_d;
    logic                err_q, err_d;
    logic                run_q;
    logic                busy_q;

    // The bits already held plus the one on the pin this cycle form the frame when it completes.
    logic [FRAME_LEN-1:0] frame;
    logic                 parity_ok;
    logic                 own_cs_n;
    logic                 other_cs_n;

    assign frame      = {shreg_q, bus.mosi_in};
    assign own_cs_n   = (state_q == SHIFT_I) ? bus.csi_n : bus.csd_n;
    assign other_cs_n = (state_q == SHIFT_I) ? bus.csd_n : bus.csi_n;
`ifdef LOADER_PARITY_EN
    assign parity_ok  = ~^frame;
`else
    assign parity_ok  = 1'b1;
`endif

    always_comb begin
        // NOTE: every _d starts from a default so no path through this block can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        addr_d  = addr_q;
        data_d  = data_q;
        iwen_d  = 1'b0;
        dwen_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.run_in) begin
                    state_d = RUN;
                    err_d   = 1'b0;
                end else if (!bus.csi_n && !bus.csd_n) begin
                    err_d = 1'b1;
                end else if (!bus.csi_n || !bus.csd_n) begin
                    state_d = bus.csi_n ? SHIFT_D : SHIFT_I;
                    shreg_d = frame[SHREG_W-1:0];
                    cnt_d   = CNT_W'(1);
                end
            end
            SHIFT_I, SHIFT_D: begin
                if (!other_cs_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (own_cs_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (cnt_q != '0) err_d = 1'b1;
                end else begin
                    shreg_d = frame[SHREG_W-1:0];
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (parity_ok) begin
                            data_d = frame[FRAME_LEN-1 -: DATA_W];
                            addr_d = frame[FRAME_LEN-DATA_W-1 -: ADDR_W];
                            iwen_d = (state_q == SHIFT_I);
                            dwen_d = (state_q == SHIFT_D);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (!bus.run_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            iwen_q  <= 1'b0;
            dwen_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            iwen_q  <= iwen_d;
            dwen_q  <= dwen_d;
            err_q   <= err_d;
            run_q   <= (state_d == RUN);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.wr_addr_out    = addr_q;
    assign bus.wr_data_out    = data_q;
    assign bus.icache_wen_out = iwen_q;
    assign bus.dcache_wen_out = dwen_q;
    assign bus.run_out        = run_q;
    assign bus.busy_out       = busy_q;
    assign bus.frame_err_out  = err_q;
endmodule

// File: tb/tb_spi_load_ctrl.sv
// Directed and randomized bench for spi_load_ctrl, checked against a frame-level reference model.
module tb_spi_load_ctrl;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = DATA_W + ADDR_W;
`ifdef LOADER_PARITY_EN
    localparam int FL = PAYLOAD_W + 1;
`else
    localparam int FL = PAYLOAD_W;
`endif

    logic clk = 1'b0;
    logic rst;

    spi_load_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    spi_load_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int exp_data = 0;
    int exp_addr = 0;
    bit exp_err  = 1'b0;
    bit stim_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wen is {icache, dcache}
    task automatic check_out(input string tag, input logic [1:0] wen, input bit busy, input bit run);
        check({tag, ".wen"},  {30'd0, bus.icache_wen_out, bus.dcache_wen_out}, {30'd0, wen});
        check({tag, ".data"}, 32'(bus.wr_data_out), 32'(exp_data));
        check({tag, ".addr"}, 32'(bus.wr_addr_out), 32'(exp_addr));
        check({tag, ".err"},  32'(bus.frame_err_out), 32'(exp_err));
        check({tag, ".busy"}, 32'(bus.busy_out), 32'(busy));
        check({tag, ".run"},  32'(bus.run_out), 32'(run));
    endtask

    task automatic add_frame(input int data, input int addr, input bit bad);
        logic [PAYLOAD_W-1:0] p;
        p = {data[DATA_W-1:0], addr[ADDR_W-1:0]};
        for (int i = PAYLOAD_W - 1; i >= 0; i--) stim_q.push_back(p[i]);
`ifdef LOADER_PARITY_EN
        stim_q.push_back((^p) ^ bad);
`else
        if (bad) stim_q.push_back(1'b0);
        if (bad) void'(stim_q.pop_back());
`endif
    endtask

    function automatic bit frame_good(input logic [FL-1:0] f);
`ifdef LOADER_PARITY_EN
        return (^f) == 1'b0;
`else
        return f === f;
`endif
    endfunction

    // Plays stim_q on one chip select, then ends cleanly or by pulling the other select low.
    task automatic stream(input bit dsel, input bit collide);
        int            n;
        logic [1:0]    wen;
        logic [FL-1:0] f;
        n = stim_q.size();
        for (int j = 0; j < n; j++) begin
            bus.csi_n   = dsel;
            bus.csd_n   = !dsel;
            bus.mosi_in = stim_q[j];
            step();
            wen = 2'b00;
            if ((j + 1) % FL == 0) begin
                for (int b = 0; b < FL; b++) f[FL-1-b] = stim_q[j+1-FL+b];
                if (frame_good(f)) begin
                    exp_data = int'(f[FL-1 -: DATA_W]);
                    exp_addr = int'(f[FL-DATA_W-1 -: ADDR_W]);
                    wen      = dsel ? 2'b01 : 2'b10;
                end else begin
                    exp_err = 1'b1;
                end
            end
            check_out("shift", wen, 1'b1, 1'b0);
        end
        if (collide) begin
            bus.csi_n = 1'b0;
            bus.csd_n = 1'b0;
            step();
            exp_err = 1'b1;
            check_out("collide", 2'b00, 1'b0, 1'b0);
        end else begin
            bus.csi_n = 1'b1;
            bus.csd_n = 1'b1;
            step();
            if (n % FL != 0) exp_err = 1'b1;
            check_out("end", 2'b00, 1'b0, 1'b0);
        end
        bus.csi_n = 1'b1;
        bus.csd_n = 1'b1;
        step();
        check_out("idle", 2'b00, 1'b0, 1'b0);
        stim_q.delete();
    endtask

    task automatic run_phase(input int m);
        bus.run_in = 1'b1;
        step();
        exp_err = 1'b0;
        check_out("run_entry", 2'b00, 1'b1, 1'b1);
        for (int j = 0; j < m; j++) begin
            bus.csi_n   = j[0];
            bus.csd_n   = 1'($urandom_range(0, 1));
            bus.mosi_in = 1'($urandom_range(0, 1));
            step();
            check_out("run_hold", 2'b00, 1'b1, 1'b1);
        end
        bus.run_in = 1'b0;
        bus.csi_n  = 1'b1;
        bus.csd_n  = 1'b1;
        step();
        check_out("run_exit", 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dsel;
        int nfr;
        rst         = 1'b1;
        bus.csi_n   = 1'b1;
        bus.csd_n   = 1'b1;
        bus.run_in  = 1'b0;
        bus.mosi_in = 1'b0;
        step();
        step();
        check_out("reset", 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("post_reset", 2'b00, 1'b0, 1'b0);

        add_frame('hA5, 'h3, 1'b0);
        stream(1'b0, 1'b0);

        add_frame('h11, 'h0, 1'b0);
        add_frame('hFE, 'hF, 1'b0);
        stream(1'b1, 1'b0);

        add_frame('hC3, 'h6, 1'b0);
        while (stim_q.size() > 7) void'(stim_q.pop_back());
        stream(1'b0, 1'b0);
        run_phase(2);

        bus.csi_n = 1'b0;
        bus.csd_n = 1'b0;
        step();
        exp_err = 1'b1;
        check_out("idle_both", 2'b00, 1'b0, 1'b0);
        bus.csi_n = 1'b1;
        bus.csd_n = 1'b1;
        step();
        check_out("idle_both_rel", 2'b00, 1'b0, 1'b0);
        run_phase(12);

        add_frame('h77, 'h2, 1'b0);
        while (stim_q.size() > 5) void'(stim_q.pop_back());
        stream(1'b0, 1'b1);

        add_frame('h5A, 'h9, 1'b0);
        for (int j = 0; j < 11; j++) begin
            bus.csi_n   = 1'b0;
            bus.mosi_in = stim_q[j];
            step();
            check_out("pre_rst", 2'b00, 1'b1, 1'b0);
        end
        bus.mosi_in = stim_q[11];
        rst = 1'b1;
        step();
        exp_data = 0;
        exp_addr = 0;
        exp_err  = 1'b0;
        check_out("rst_mid", 2'b00, 1'b0, 1'b0);
        rst       = 1'b0;
        bus.csi_n = 1'b1;
        step();
        check_out("rst_rel", 2'b00, 1'b0, 1'b0);
        stim_q.delete();

        add_frame('hA5, 'h3, 1'b1);
        add_frame('hA5, 'h3, 1'b0);
        stream(1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            dsel = 1'($urandom_range(0, 1));
            nfr  = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++)
                add_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                          $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, FL - 1)) void'(stim_q.pop_back());
            stream(dsel, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) run_phase(int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
